siso_shift_register: RTL and testbench

SISO_SHIFT_REGISTER -- requirements
Module: siso_shift_register

---
 rtl/siso_shift_register.sv | 64 ++++++
 tb/tb_siso_shift_register.sv | 137 +++++++++++++
 2 files changed

// File: rtl/siso_shift_register.sv
// Serial-in/serial-out shift register with a saturating fill flag.
// Optional parallel tap of the stage register when SISO_PAR_OUT_EN is defined.
module siso_shift_register #(
    parameter int              WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             s_in,
    output logic             s_out,
`ifdef SISO_PAR_OUT_EN
    output logic [WIDTH-1:0] p_out,
`endif
    output logic             full
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] temp;
    logic [WIDTH-1:0] temp_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;

    // A one-bit register simply captures s_in; wider ones drop the oldest bit.
    generate
        if (WIDTH == 1) begin : g_w1
            assign temp_nxt_s = s_in;
        end else begin : g_wn
            assign temp_nxt_s = {temp[WIDTH-2:0], s_in};
        end
    endgenerate

    // Fill counter next value, saturating at WIDTH.
    always_comb begin
        count_nxt_s = count_r;
        if (count_r == CNT_MAX) begin
            count_nxt_s = count_r;
        end else begin
            count_nxt_s = count_r + CNT_W'(1);
        end
    end

    // Stage register, fill counter and full flag; reset wins over any shift.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            temp    <= RST_VAL;
            count_r <= {CNT_W{1'b0}};
            full_r  <= 1'b0;
        end else begin
            temp    <= temp_nxt_s;
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_MAX);
        end
    end

    assign s_out = temp[WIDTH-1];
    assign full  = full_r;
`ifdef SISO_PAR_OUT_EN
    assign p_out = temp;
`endif

endmodule

// File: tb/tb_siso_shift_register.sv
// Directed bench for siso_shift_register: WIDTH=4 main instance plus WIDTH=1 and WIDTH=8.
module tb_siso_shift_register;

    logic       clk = 1'b0;
    logic       arstn;
    logic       s_in;
    logic       s_out4, full4;
    logic       s_out1, full1;
    logic       s_out8, full8;
`ifdef SISO_PAR_OUT_EN
    logic [3:0] p_out4;
    logic [0:0] p_out1;
    logic [7:0] p_out8;
`endif

    int passed = 0;
    int total  = 0;

    logic [3:0] exp4  [0:7];
    logic [7:0] exp8  [0:7];
    logic       pat   [0:7];

    always #5 clk = ~clk;

    siso_shift_register #(.WIDTH(4)) dut (
        .clk(clk), .arstn(arstn), .s_in(s_in), .s_out(s_out4),
`ifdef SISO_PAR_OUT_EN
        .p_out(p_out4),
`endif
        .full(full4)
    );

    siso_shift_register #(.WIDTH(1)) dut1 (
        .clk(clk), .arstn(arstn), .s_in(s_in), .s_out(s_out1),
`ifdef SISO_PAR_OUT_EN
        .p_out(p_out1),
`endif
        .full(full1)
    );

    siso_shift_register #(.WIDTH(8)) dut8 (
        .clk(clk), .arstn(arstn), .s_in(s_in), .s_out(s_out8),
`ifdef SISO_PAR_OUT_EN
        .p_out(p_out8),
`endif
        .full(full8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive s_in, take one rising edge, then settle just after it.
    task automatic step(input logic b);
        s_in = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp4 = '{4'h1, 4'h2, 4'h5, 4'hB, 4'h6, 4'hC, 4'h8, 4'h0};
        exp8 = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h58, 8'hB0};
        pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held for two edges with s_in=1.
        arstn = 1'b0;
        s_in  = 1'b1;
        #2;
        step(1'b1);
        step(1'b1);
        check("rst_temp", 64'(dut.temp), 64'h0);
        check("rst_s_out", 64'(s_out4), 64'h0);
        check("rst_full", 64'(full4), 64'h0);
        check("rst_temp8", 64'(dut8.temp), 64'h0);
        check("rst_s_out1", 64'(s_out1), 64'h0);

        // Pattern 1,0,1,1,0 then zeros on edges k..k+7.
        arstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(pat[i]);
            check($sformatf("pat_temp[%0d]", i), 64'(dut.temp), 64'(exp4[i]));
            check($sformatf("pat_s_out[%0d]", i), 64'(s_out4), 64'(exp4[i][3]));
            check($sformatf("pat_full[%0d]", i), 64'(full4), (i >= 3) ? 64'h1 : 64'h0);
            check($sformatf("w1_s_out[%0d]", i), 64'(s_out1), 64'(pat[i]));
            check($sformatf("w8_temp[%0d]", i), 64'(dut8.temp), 64'(exp8[i]));
            check($sformatf("w8_s_out[%0d]", i), 64'(s_out8), (i == 7) ? 64'h1 : 64'h0);
            check($sformatf("w8_full[%0d]", i), 64'(full8), (i == 7) ? 64'h1 : 64'h0);
`ifdef SISO_PAR_OUT_EN
            check($sformatf("pat_p_out[%0d]", i), 64'(p_out4), 64'(exp4[i]));
`endif
        end

        // Full must stay set for ten more edges.
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            check($sformatf("full_hold[%0d]", i), 64'(full4), 64'h1);
        end
        check("drain_temp", 64'(dut.temp), 64'h0);

        // Mid-stream reset with temp=1011 and s_in=1 on the reset edge.
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        check("mid_pre_temp", 64'(dut.temp), 64'hB);
        arstn = 1'b0;
        step(1'b1);
        check("mid_rst_temp", 64'(dut.temp), 64'h0);
        check("mid_rst_full", 64'(full4), 64'h0);
        check("mid_rst_s_out", 64'(s_out4), 64'h0);
        arstn = 1'b1;
        step(1'b1);
        check("mid_resume_temp", 64'(dut.temp), 64'h1);
        check("mid_resume_full", 64'(full4), 64'h0);

        // Three more ones complete an all-ones fill.
        step(1'b1);
        step(1'b1);
        check("ones_full_pre", 64'(full4), 64'h0);
        step(1'b1);
        check("ones_temp", 64'(dut.temp), 64'hF);
        check("ones_full", 64'(full4), 64'h1);
        check("ones_s_out", 64'(s_out4), 64'h1);
`ifdef SISO_PAR_OUT_EN
        check("ones_p_out", 64'(p_out4), 64'hF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
